// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide controller.
package muldiv_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned STEPS = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_PASS = 2'b10;
    localparam logic [1:0] MODE_DEC  = 2'b11;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between a master and the multiply/divide controller.
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             dbz;

    modport master (
        output start, op, a, b,
        input  busy, done, result_hi, result_lo, dbz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_hi, result_lo, dbz
    );

endinterface

// File: rtl/muldiv_seq_arithunit.sv
// 8-bit combinational adder with B-operand select: B, ~B, 0 or FF plus carry in.
module arithunit
    import muldiv_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             s1,
    input  logic             s0,
    input  logic             C_in,
    output logic [WIDTH-1:0] D,
    output logic             C_out,
    output logic             z
);

    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   sum;

    // Operand select and add
    always_comb begin
        b_sel = B;
        case ({s1, s0})
            MODE_ADD:  b_sel = B;
            MODE_SUB:  b_sel = ~B;
            MODE_PASS: b_sel = '0;
            MODE_DEC:  b_sel = '1;
            default:   b_sel = B;
        endcase
        sum   = {1'b0, A} + {1'b0, b_sel} + (WIDTH+1)'(C_in);
        D     = sum[WIDTH-1:0];
        C_out = sum[WIDTH];
        z     = (sum[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 8-bit unsigned multiply (shift-add) / divide (restoring) controller.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] au_a;
    logic [1:0]       au_mode;
    logic             au_cin;
    logic [WIDTH-1:0] au_d;
    logic             au_cout;
    logic             au_z_unused;
    logic [WIDTH-1:0] rs;
    logic             qbit;

    // Divide: remainder shifted left with the next dividend bit
    assign rs = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};

    arithunit au (
        .A     (au_a),
        .B     (m_q),
        .s1    (au_mode[1]),
        .s0    (au_mode[0]),
        .C_in  (au_cin),
        .D     (au_d),
        .C_out (au_cout),
        .z     (au_z_unused)
    );

    // Arithunit operand/mode steering; pass-through when not iterating
    always_comb begin
        au_a    = acc_q;
        au_mode = MODE_PASS;
        au_cin  = 1'b0;
        case (state_q)
            MUL: begin
                au_a    = acc_q;
                au_mode = q_q[0] ? MODE_ADD : MODE_PASS;
                au_cin  = 1'b0;
            end
            DIV: begin
                au_a    = rs;
                au_mode = MODE_SUB;
                au_cin  = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state, datapath register and output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        q_d      = q_q;
        m_d      = m_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        qbit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    m_d   = bus.b;
                    q_d   = bus.a;
                    dbz_d = 1'b0;
                    if (bus.op == OP_MUL) begin
                        acc_d   = '0;
                        state_d = MUL;
                    end else if (bus.b != '0) begin
                        rem_d   = '0;
                        state_d = DIV;
                    end else begin
                        dbz_d    = 1'b1;
                        res_lo_d = '1;
                        res_hi_d = bus.a;
                        state_d  = DONE;
                    end
                end
            end
            MUL: begin
                acc_d = {au_cout, au_d[WIDTH-1:1]};
                q_d   = {au_d[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    res_hi_d = acc_d;
                    res_lo_d = q_d;
                    state_d  = DONE;
                end
            end
            DIV: begin
                if (rem_q[WIDTH-1] | au_cout) begin
                    rem_d = au_d;
                    qbit  = 1'b1;
                end else begin
                    rem_d = rs;
                end
                q_d   = {q_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    res_hi_d = rem_d;
                    res_lo_d = q_d;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            q_q      <= q_d;
            m_q      <= m_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_hi = res_hi_q;
    assign bus.result_lo = res_lo_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain arithmetic on the operands
    task automatic model(input logic op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] hi, output logic [7:0] lo, output logic dbz,
                         output int lat);
        logic [15:0] p;
        if (op == 1'b0) begin
            p   = 16'(a) * 16'(b);
            hi  = p[15:8];
            lo  = p[7:0];
            dbz = 1'b0;
            lat = 9;
        end else if (b == 8'd0) begin
            hi  = a;
            lo  = 8'hFF;
            dbz = 1'b1;
            lat = 1;
        end else begin
            hi  = a % b;
            lo  = a / b;
            dbz = 1'b0;
            lat = 9;
        end
    endtask

    // Issue one request and wait for done; returns outputs, latency and accept cycle
    task automatic do_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] hi, output logic [7:0] lo, output logic dbz,
                         output int lat, output logic busy1, output int acc_cyc);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
        busy1     = bus.busy;
        lat       = 1;
        while (!bus.done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles (op=%0d a=%0d b=%0d)", lat, op, a, b);
        end
        hi  = bus.result_hi;
        lo  = bus.result_lo;
        dbz = bus.dbz;
    endtask

    // Run one operation and compare every observable against the model
    task automatic check_op(input string name, input logic op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] hi, lo, ehi, elo;
        logic       dbz, edbz, busy1;
        int         lat, elat, ac;
        model(op, a, b, ehi, elo, edbz, elat);
        do_op(op, a, b, hi, lo, dbz, lat, busy1, ac);
        n_checks++;
        if (lat !== elat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        n_checks++;
        if ({hi, lo} !== {ehi, elo}) begin
            n_fail++;
            $display("FAIL %s result (op=%0d a=%0d b=%0d): got %h expected %h", name, op, a, b, {hi, lo}, {ehi, elo});
        end
        n_checks++;
        if (dbz !== edbz) begin
            n_fail++;
            $display("FAIL %s dbz: got %0b expected %0b", name, dbz, edbz);
        end
        n_checks++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy after accept: got %0b expected 1", name, busy1);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.dbz} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset flags: got busy/done/dbz=%b expected 000", {bus.busy, bus.done, bus.dbz});
        end
        n_checks++;
        if ({bus.result_hi, bus.result_lo} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset results: got %h expected 0000", {bus.result_hi, bus.result_lo});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle busy: got %0b expected 0", bus.busy);
        end
    endtask

    task automatic test_mul();
        check_op("mul_13x11", 1'b0, 8'd13, 8'd11);
        check_op("mul_255x255", 1'b0, 8'd255, 8'd255);
        check_op("mul_x0", 1'b0, 8'd77, 8'd0);
    endtask

    task automatic test_div();
        check_op("div_200_7", 1'b1, 8'd200, 8'd7);
        check_op("div_255_1", 1'b1, 8'd255, 8'd1);
        check_op("div_5_9", 1'b1, 8'd5, 8'd9);
        check_op("div_255_128", 1'b1, 8'd255, 8'd128);
    endtask

    task automatic test_dbz();
        check_op("div_by_zero", 1'b1, 8'h5A, 8'd0);
        check_op("after_dbz_mul", 1'b0, 8'd4, 8'd4);
    endtask

    // Starts during busy and during DONE must be dropped
    task automatic test_ignored_start();
        int n_done, done_at;
        n_done  = 0;
        done_at = -1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 8'd3;
        bus.b     = 8'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                n_done++;
                done_at = c;
                n_checks++;
                if ({bus.result_hi, bus.result_lo} !== 16'h000F) begin
                    n_fail++;
                    $display("FAIL ignore_start result: got %h expected 000f", {bus.result_hi, bus.result_lo});
                end
            end
            bus.start = (c == 3 || c == 9);
            bus.op    = 1'b1;
            bus.a     = 8'd100;
            bus.b     = 8'd3;
        end
        bus.start = 1'b0;
        n_checks++;
        if (n_done !== 1 || done_at !== 9) begin
            n_fail++;
            $display("FAIL ignore_start done count/cycle: got %0d at %0d expected 1 at 9", n_done, done_at);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start idle: got busy=%0b expected 0", bus.busy);
        end
    endtask

    // Asynchronous reset in the middle of a multiply
    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 8'd200;
        bus.b     = 8'd200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset flags: got busy/done=%b expected 00", {bus.busy, bus.done});
        end
        n_checks++;
        if ({bus.result_hi, bus.result_lo} !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset results: got %h expected 0000", {bus.result_hi, bus.result_lo});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL mid_reset activity after release: got %0d cycles expected 0", n_done);
        end
        check_op("mul_2x3_after_reset", 1'b0, 8'd2, 8'd3);
    endtask

    // Start in the cycle right after DONE: accepts every 10 cycles
    task automatic test_back_to_back();
        logic [7:0] hi, lo;
        logic       dbz, busy1;
        int         lat, c0, c1;
        do_op(1'b0, 8'd9, 8'd9, hi, lo, dbz, lat, busy1, c0);
        do_op(1'b1, 8'd99, 8'd10, hi, lo, dbz, lat, busy1, c1);
        n_checks++;
        if (c1 - c0 !== 10) begin
            n_fail++;
            $display("FAIL back_to_back period: got %0d expected 10", c1 - c0);
        end
        n_checks++;
        if ({hi, lo} !== {8'd9, 8'd9}) begin
            n_fail++;
            $display("FAIL back_to_back result: got %h expected 0909", {hi, lo});
        end
    endtask

    task automatic test_random();
        logic       op;
        logic [7:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            check_op("random", op, a, b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        test_reset();
        test_mul();
        test_div();
        test_dbz();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
